// File: rtl/chiptune_mixer_if.sv
// ---------------------------------------------------------------------------
// chiptune_mixer_if
// Parallel register-write port of the chiptune mixer.
//   wr_en    1      write strobe, one write per cycle
//   wr_addr  AW     {channel index, register index[1:0]}
//   wr_data  8      write data
// Modports: master (register writer), slave (mixer).
// AW = 2 + max(1, clog2(NUM_CH)).
// ---------------------------------------------------------------------------
interface chiptune_mixer_if #(
  parameter int NUM_CH = 2
);
  localparam int CH_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = 2 + CH_W;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/chiptune_mixer.sv
// ---------------------------------------------------------------------------
// chiptune_mixer
// NUM_CH NES-style rectangle channels (duty sequencer, envelope, length
// counter) clocked by an internal 240/120 Hz frame sequencer, mixed into one
// saturating registered DAC word.
//   clk           system clock
//   rst           synchronous reset, active-high
//   wr_bus        register write port (slave modport)
//   quarter_tick  one-clock 240 Hz pulse
//   half_tick     one-clock 120 Hz pulse, every second quarter_tick
//   ch_active     bit n = length counter of channel n is non-zero
//   dac           mixed audio sample, min(sum of levels, 2^DAC_W-1)
// Register map per channel (reg = wr_addr[1:0]):
//   0: duty[7:6] halt[5] const[4] vol[3:0]
//   1: enable[0]
//   2: period[7:0]
//   3: length index[7:3] period[10:8]
// ---------------------------------------------------------------------------
module chiptune_mixer #(
  parameter int CLKRATE = 4800,
  parameter int NUM_CH  = 2,
  parameter int DAC_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  chiptune_mixer_if.slave   wr_bus,
  output logic              quarter_tick,
  output logic              half_tick,
  output logic [NUM_CH-1:0] ch_active,
  output logic [DAC_W-1:0]  dac
);

  localparam int QP      = CLKRATE / 240;
  localparam int FC_W    = (QP > 1) ? $clog2(QP) : 1;
  localparam int CH_W    = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW      = 2 + CH_W;
  localparam int SUM_W   = 4 + $clog2(NUM_CH + 1);
  localparam int DAC_MAX = (1 << DAC_W) - 1;

  // Step positions where the rectangle output is high, per duty setting.
  function automatic logic duty_high(input logic [1:0] duty, input logic [2:0] step);
    logic hi;
    case (duty)
      2'd0:    hi = (step == 3'd1);
      2'd1:    hi = (step == 3'd1) || (step == 3'd2);
      2'd2:    hi = (step >= 3'd1) && (step <= 3'd4);
      default: hi = (step == 3'd0) || (step >= 3'd3);
    endcase
    return hi;
  endfunction

  // -------------------------------------------------------------------------
  // Frame sequencer
  // -------------------------------------------------------------------------
  logic [FC_W-1:0] r_frame_cnt;
  logic            r_half_phase;
  logic            r_quarter_tick;
  logic            r_half_tick;

  // NOTE: sequential state uses non-blocking assignments so every block
  // samples the pre-edge values of all registers, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_cnt    <= '0;
      r_half_phase   <= 1'b0;
      r_quarter_tick <= 1'b0;
      r_half_tick    <= 1'b0;
    end else begin
      r_quarter_tick <= 1'b0;
      r_half_tick    <= 1'b0;
      if (r_frame_cnt == FC_W'(QP - 1)) begin
        r_frame_cnt    <= '0;
        r_quarter_tick <= 1'b1;
        // The first wrap after reset is a quarter only; halves follow on
        // every second wrap.
        r_half_tick    <= r_half_phase;
        r_half_phase   <= ~r_half_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  assign quarter_tick = r_quarter_tick;
  assign half_tick    = r_half_tick;

  // -------------------------------------------------------------------------
  // Channels
  // -------------------------------------------------------------------------
  logic [CH_W-1:0]   w_ch;
  logic [1:0]        w_reg;
  logic [6:0]        w_len_load;
  logic [3:0]        w_level  [NUM_CH];
  logic [NUM_CH-1:0] w_len_nz;

  assign w_ch       = wr_bus.wr_addr[AW-1:2];
  assign w_reg      = wr_bus.wr_addr[1:0];
  // 2*(L+1) for the 5-bit length index in wr_data[7:3].
  assign w_len_load = 7'({wr_bus.wr_data[7:3], 1'b0}) + 7'd2;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    logic        w_sel;
    logic        w_wr0, w_wr1, w_wr2, w_wr3;
    logic [1:0]  r_duty;
    logic        r_halt, r_const, r_enable, r_start;
    logic [3:0]  r_vol, r_divider, r_decay, r_level;
    logic [10:0] r_period, r_timer;
    logic [2:0]  r_step;
    logic [6:0]  r_length;

    // Channel indices >= NUM_CH have no generated slice, so such writes
    // match nothing and are dropped.
    assign w_sel = wr_bus.wr_en && (w_ch == CH_W'(n));
    assign w_wr0 = w_sel && (w_reg == 2'd0);
    assign w_wr1 = w_sel && (w_reg == 2'd1);
    assign w_wr2 = w_sel && (w_reg == 2'd2);
    assign w_wr3 = w_sel && (w_reg == 2'd3);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_duty    <= '0;
        r_halt    <= 1'b0;
        r_const   <= 1'b0;
        r_vol     <= '0;
        r_enable  <= 1'b0;
        r_period  <= '0;
        r_timer   <= '0;
        r_step    <= '0;
        r_length  <= '0;
        r_start   <= 1'b0;
        r_divider <= '0;
        r_decay   <= '0;
        r_level   <= '0;
      end else begin
        if (w_wr0) {r_duty, r_halt, r_const, r_vol} <= wr_bus.wr_data;
        if (w_wr1) r_enable <= wr_bus.wr_data[0];
        if (w_wr2) r_period[7:0] <= wr_bus.wr_data;
        if (w_wr3) r_period[10:8] <= wr_bus.wr_data[2:0];

        // Period writes only take effect at the next reload.
        if (r_timer == 11'd0) begin
          r_timer <= r_period;
          r_step  <= r_step + 3'd1;
        end else begin
          r_timer <= r_timer - 11'd1;
        end
        // NOTE: a later non-blocking assignment to the same register in the
        // same block wins, which is how a reg-3 write overrides the step
        // advance (and, below, the envelope's flag clear).
        if (w_wr3) r_step <= 3'd0;

        // Disable beats load beats the half-frame decrement.
        if (w_wr1 && !wr_bus.wr_data[0]) begin
          r_length <= '0;
        end else if (w_wr3 && r_enable) begin
          r_length <= w_len_load;
        end else if (r_half_tick && (r_length != 7'd0) && !r_halt) begin
          r_length <= r_length - 7'd1;
        end

        // Envelope runs from pre-write state; a same-cycle reg-3 write
        // leaves the start flag set for the next quarter.
        if (r_quarter_tick) begin
          if (r_start) begin
            r_start   <= 1'b0;
            r_decay   <= 4'd15;
            r_divider <= r_vol;
          end else if (r_divider == 4'd0) begin
            r_divider <= r_vol;
            if (r_decay != 4'd0) r_decay <= r_decay - 4'd1;
            else if (r_halt)     r_decay <= 4'd15;
          end else begin
            r_divider <= r_divider - 4'd1;
          end
        end
        if (w_wr3) r_start <= 1'b1;

        // Periods below 8 are ultrasonic and muted.
        if (duty_high(r_duty, r_step) && (r_length != 7'd0) && r_enable &&
            (r_period >= 11'd8))
          r_level <= r_const ? r_vol : r_decay;
        else
          r_level <= 4'd0;
      end
    end

    assign w_level[n]  = r_level;
    assign w_len_nz[n] = (r_length != 7'd0);
  end

  // -------------------------------------------------------------------------
  // Mixer
  // -------------------------------------------------------------------------
  logic [SUM_W-1:0]  w_sum;
  logic [NUM_CH-1:0] r_active;
  logic [DAC_W-1:0]  r_dac;

  // NOTE: every combinational output gets a default before the loop, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_CH; i++) w_sum = w_sum + SUM_W'(w_level[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= '0;
      r_dac    <= '0;
    end else begin
      r_active <= w_len_nz;
      if (int'(w_sum) > DAC_MAX) r_dac <= DAC_W'(DAC_MAX);
      else                       r_dac <= DAC_W'(w_sum);
    end
  end

  assign ch_active = r_active;
  assign dac       = r_dac;

endmodule

// File: tb/tb_chiptune_mixer.sv
// ---------------------------------------------------------------------------
// tb_chiptune_mixer
// Directed stimulus on an absolute clock-cycle timeline. Each stimulus step
// pushes the expected output values, tagged with the cycle they are due, into
// a scoreboard queue; a monitor on the falling edge pops and compares every
// entry due in the current cycle. A second instance (4 channels, 4-bit DAC)
// covers saturation.
// Cycle n = state after the n-th rising edge. A write driven in cycle n is
// sampled at edge n+1, so its register effect is visible in cycle n+1.
// ---------------------------------------------------------------------------
module tb_chiptune_mixer;

  typedef enum int {S_DAC, S_QT, S_HT, S_ACT, S_SDAC} sig_e;
  typedef struct {
    int    cyc;
    sig_e  sig;
    int    val;
    string name;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       sb[$];

  logic       qt2, ht2, qt4, ht4;
  logic [1:0] act2;
  logic [3:0] act4;
  logic [4:0] dac2;
  logic [3:0] dac4;

  chiptune_mixer_if #(.NUM_CH(2)) bus2 ();
  chiptune_mixer_if #(.NUM_CH(4)) bus4 ();

  chiptune_mixer #(.CLKRATE(4800), .NUM_CH(2), .DAC_W(5)) u_dut (
    .clk(clk), .rst(rst), .wr_bus(bus2),
    .quarter_tick(qt2), .half_tick(ht2), .ch_active(act2), .dac(dac2)
  );

  chiptune_mixer #(.CLKRATE(4800), .NUM_CH(4), .DAC_W(4)) u_sat (
    .clk(clk), .rst(rst), .wr_bus(bus4),
    .quarter_tick(qt4), .half_tick(ht4), .ch_active(act4), .dac(dac4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      S_DAC:   return 32'(dac2);
      S_QT:    return 32'(qt2);
      S_HT:    return 32'(ht2);
      S_ACT:   return 32'(act2);
      default: return 32'(dac4);
    endcase
  endfunction

  task automatic exp_at(input int c, input sig_e s, input int v, input string n);
    exp_t e;
    e.cyc = c; e.sig = s; e.val = v; e.name = n;
    sb.push_back(e);
  endtask

  // Monitor: compare every scoreboard entry due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check(sb[i].name, sample(sb[i].sig), 32'(sb[i].val));
        sb.delete(i);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr2(input int c, input logic [2:0] a, input logic [7:0] d);
    goto(c);
    check("sched2", cyc, c);
    bus2.wr_en = 1'b1; bus2.wr_addr = a; bus2.wr_data = d;
    goto(c + 1);
    bus2.wr_en = 1'b0;
  endtask

  task automatic wr4(input int c, input logic [3:0] a, input logic [7:0] d);
    goto(c);
    check("sched4", cyc, c);
    bus4.wr_en = 1'b1; bus4.wr_addr = a; bus4.wr_data = d;
    goto(c + 1);
    bus4.wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus2.wr_en = 1'b0; bus2.wr_addr = '0; bus2.wr_data = '0;
    bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0;

    // Reset: everything 0 while rst is high; last reset edge is cycle 3.
    for (int c = 1; c <= 3; c++) begin
      exp_at(c, S_DAC, 0, "rst_dac");
      exp_at(c, S_QT, 0, "rst_qt");
      exp_at(c, S_HT, 0, "rst_ht");
      exp_at(c, S_ACT, 0, "rst_act");
      exp_at(c, S_SDAC, 0, "rst_sdac");
    end
    // Frame timing: quarter every 20 clocks from cycle 23, half every 40 from 43.
    for (int c = 4; c <= 100; c++) begin
      exp_at(c, S_QT, ((c - 3) % 20 == 0) ? 1 : 0, "frame_qt");
      exp_at(c, S_HT, ((c - 3) % 40 == 0) ? 1 : 0, "frame_ht");
    end
    goto(3);
    rst = 1'b0;

    // Constant tone, ch0: step reload every 10 clocks from edge 104,
    // dac high 116..155, low 156..195, high 196..235.
    exp_at(104, S_ACT, 0, "tone_act_pre");
    exp_at(105, S_ACT, 1, "tone_act");
    exp_at(115, S_DAC, 0, "tone_lo0");
    exp_at(116, S_DAC, 15, "tone_hi0");
    exp_at(155, S_DAC, 15, "tone_hi1");
    exp_at(156, S_DAC, 0, "tone_lo1");
    exp_at(195, S_DAC, 0, "tone_lo2");
    exp_at(196, S_DAC, 15, "tone_hi2");
    exp_at(235, S_DAC, 15, "tone_hi3");
    exp_at(236, S_DAC, 0, "tone_lo3");
    exp_at(230, S_ACT, 1, "tone_act_hold");
    exp_at(241, S_ACT, 1, "dis_act_lag");
    exp_at(242, S_ACT, 0, "dis_act");
    wr2(100, 3'd1, 8'h01);
    wr2(101, 3'd0, 8'hBF);
    wr2(102, 3'd2, 8'h09);
    wr2(103, 3'd3, 8'hF8);
    wr2(240, 3'd1, 8'h00);

    // Length expiry: length 4 at 264, half ticks 283/323/363/403.
    exp_at(275, S_DAC, 0, "len_lo");
    exp_at(276, S_DAC, 15, "len_hi");
    exp_at(356, S_DAC, 15, "len_hi2");
    exp_at(404, S_ACT, 1, "len_act_last");
    exp_at(405, S_ACT, 0, "len_act_drop");
    exp_at(440, S_DAC, 0, "len_dac_silent");
    wr2(260, 3'd1, 8'h01);
    wr2(261, 3'd0, 8'h9F);
    wr2(262, 3'd2, 8'h09);
    wr2(263, 3'd3, 8'h08);

    // Envelope: reg-3 write in quarter-tick cycle 463, flag consumed at 483,
    // decay 15-j from cycle 484+20j; dac reflects decay two cycles earlier.
    exp_at(465, S_ACT, 1, "env_act");
    exp_at(486, S_DAC, 15, "env_15");
    exp_at(515, S_DAC, 14, "env_14");
    exp_at(565, S_DAC, 12, "env_12");
    exp_at(566, S_DAC, 11, "env_11");
    exp_at(640, S_DAC, 8, "env_8");
    exp_at(745, S_DAC, 3, "env_3");
    exp_at(746, S_DAC, 2, "env_2");
    exp_at(800, S_DAC, 0, "env_0");
    exp_at(830, S_DAC, 0, "env_hold0");
    // Halt=1 from 881: decay 0 -> 15 at quarter 883, 14 at 903.
    exp_at(890, S_DAC, 15, "env_wrap15");
    exp_at(906, S_DAC, 14, "env_wrap14");
    exp_at(463, S_QT, 1, "env_coll_qt");
    wr2(460, 3'd0, 8'h80);
    wr2(461, 3'd1, 8'h01);
    wr2(463, 3'd3, 8'hF8);
    wr2(880, 3'd0, 8'hA0);

    // Mute: period 7 silences a const V=15 tone.
    for (int c = 1010; c <= 1080; c += 10) exp_at(c, S_DAC, 0, "mute_dac");
    wr2(1000, 3'd0, 8'hBF);
    wr2(1001, 3'd2, 8'h07);
    wr2(1100, 3'd1, 8'h00);

    // Collision on ch1: length 10, disable in half-tick cycle 1123.
    exp_at(1103, S_QT, 1, "coll_qt_a");
    exp_at(1103, S_HT, 0, "coll_ht_a");
    exp_at(1123, S_QT, 1, "coll_qt_b");
    exp_at(1123, S_HT, 1, "coll_ht_b");
    exp_at(1109, S_ACT, 2, "coll_act_on");
    exp_at(1124, S_ACT, 2, "coll_act_lag");
    exp_at(1125, S_ACT, 0, "coll_act_off");
    exp_at(1132, S_ACT, 0, "coll_noload");
    exp_at(1140, S_ACT, 0, "coll_noload2");
    exp_at(1140, S_DAC, 0, "coll_dac");
    wr2(1105, 3'd5, 8'h01);
    wr2(1106, 3'd4, 8'h9F);
    wr2(1107, 3'd7, 8'h20);
    wr2(1123, 3'd5, 8'h00);
    wr2(1130, 3'd7, 8'hF8);

    // Saturation: four aligned-enough channels, duty3, const V=15.
    // All in step 1/2 (low) around 1220..1230, all in step 5 (high) at 1258.
    exp_at(1220, S_SDAC, 0, "sat_lo1");
    exp_at(1230, S_SDAC, 0, "sat_lo2");
    exp_at(1260, S_SDAC, 15, "sat_full");
    for (int n = 0; n < 4; n++) wr4(1190 + n, 4'(n * 4 + 1), 8'h01);
    for (int n = 0; n < 4; n++) wr4(1194 + n, 4'(n * 4 + 0), 8'hFF);
    for (int n = 0; n < 4; n++) wr4(1200 + n, 4'(n * 4 + 2), 8'h09);
    for (int n = 0; n < 4; n++) wr4(1210 + n, 4'(n * 4 + 3), 8'hF8);

    goto(1300);
    @(negedge clk);
    check("sb_pending", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chiptune_mixer.md
Name: chiptune_mixer

Overview:
Parametrised multi-channel successor to the single-pulse chiptune core. It contains NUM_CH NES-style rectangle channels, each with a duty sequencer, envelope and length counter, plus an internal 240/120 Hz frame sequencer. The channels are written through a parallel register port rather than the serial decoder. Channel volumes are summed into one saturating, registered DAC word that drives the audio pins.

Parameters:
CLKRATE, 4800, system clock rate in Hz; quarter-frame period = CLKRATE/240 clocks (integer division).
NUM_CH, 2, number of rectangle channels, legal range 1..4.
DAC_W, 5, DAC output width in bits, legal range 4..6.

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  register write strobe, one write per cycle
wr_addr  input  AW  register address, AW = 2 + max(1, $clog2(NUM_CH)); channel = wr_addr[AW-1:2], reg k = wr_addr[1:0]
wr_data  input  8  write data
quarter_tick  output  1  one-clock 240 Hz pulse
half_tick  output  1  one-clock 120 Hz pulse, coincides with every second quarter_tick
ch_active  output  NUM_CH  bit n = length counter of channel n is non-zero
dac  output  DAC_W  mixed audio sample

Behaviour:
- Reset: all channel registers, timers, counters, flags and the frame counter go to 0. quarter_tick, half_tick, ch_active and dac are 0 in the cycle after rst is sampled high. Reset mid-note silences the output on the following cycle.
- Writes addressing a channel index >= NUM_CH are ignored.
- Frame sequencer: the counter runs 0..CLKRATE/240-1. quarter_tick = 1 when the counter wraps. half_tick is asserted on alternate quarter_ticks, starting with the second tick after reset.
- Reg 0: duty[7:6], halt[5], const[4], V[3:0].
- Reg 1: bit0 = enable. Writing 0 clears the length counter immediately, and loads are ignored while enable = 0.
- Reg 2: timer period [7:0].
- Reg 3: length index L[7:3], period [10:8]. A write also:
  - loads length = 2*(L+1) if enable = 1;
  - sets the envelope start flag;
  - resets the duty step to 0.
- Timer: 11-bit down-counter that decrements every clk. When it reaches 0, it reloads the period and the duty step advances (step+1 mod 8).
- Duty high steps (step 0..7):
  - duty 0: {1}
  - duty 1: {1,2}
  - duty 2: {1,2,3,4}
  - duty 3: {0,3,4,5,6,7}
- Envelope, on quarter_tick:
  - If the start flag is set: clear the flag, decay = 15, divider = V.
  - Else if divider = 0: divider = V; then if decay > 0, decay--; else if halt = 1, decay = 15.
  - Else divider--.
- Length counter, on half_tick: decrement if non-zero and halt = 0.
- Channel level = (const ? V : decay) when the duty bit is high, length != 0, enable = 1 and period >= 8. Otherwise level = 0. The level is registered.
- Mixer: sum = the sum of all channel levels (width 4 + $clog2(NUM_CH+1)). dac = min(sum, 2^DAC_W-1), registered. Latency from a timer reload to dac is 2 clocks.
- Collisions:
  - A reg-3 write in the same cycle as half_tick loads the length, with no decrement that cycle.
  - A reg-3 write in the same cycle as quarter_tick sets the start flag; the envelope is processed from the old state that cycle, and the flag is consumed on the next quarter_tick.
  - A reg-1 enable = 0 write overrides a same-cycle half_tick decrement.
- Register writes take effect on the cycle after wr_en is sampled. A period write does not restart the running timer count.

Test Plan:
- Reset/frame timing, CLKRATE=4800: release rst, then count clocks. Required: quarter_tick every 20 clocks, half_tick every 40 clocks on the second, fourth, … quarter_tick; all outputs 0 during rst.
- Constant tone: ch0 writes reg1=0x01, reg0=0xBF (duty2, halt, const, V=15), reg2=0x09, reg3=0xF8 (L=31, length 64). Required: dac toggles between 15 and 0 with a 50% duty, 80-clock period; ch_active[0]=1 indefinitely.
- Length expiry: same tone but reg0=0x9F (halt=0), reg3=0x08 (L=1, length 4). Required: ch_active[0] drops 2 clocks after the 4th half_tick following the write; dac stays 0 afterwards.
- Envelope decay: reg0=0x80 (const=0, V=0, halt=0), then a reg3 write. Required: the level is 15 after the first quarter_tick and drops by 1 on each later quarter_tick until it reaches 0, where it holds. With halt=1 it instead wraps from 0 to 15.
- Mute and saturation: period=7 gives dac=0. NUM_CH=4, DAC_W=4, all channels const V=15, duty3, aligned: required dac=15 (saturated), not 60.
- Collision: a reg-1=0x00 write coincident with half_tick while length=10. Required: length=0 and ch_active=0 the next cycle; a subsequent reg-3 write leaves length at 0.
